q2_sweep_ctrl: RTL and testbench

//  Synthesizable sweep sequencer for the 4-input q2 logic block. Upstream, it drives a,b,c,d

---
 rtl/q2_sweep_ctrl_pkg.sv | 13 +
 rtl/q2_sweep_ctrl_if.sv | 27 ++
 rtl/q2_sweep_ctrl_dwell_counter.sv | 35 +++
 rtl/q2_sweep_ctrl.sv | 103 ++++++++++
 tb/tb_q2_sweep_ctrl.sv | 150 +++++++++++++++
 5 files changed

// File: rtl/q2_sweep_ctrl_pkg.sv
// rtl/q2_sweep_ctrl_pkg.sv - shared state encoding and sweep constants for the q2 sweep controller
package q2_sweep_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int          N_COMB   = 16;
    localparam logic [3:0]  LAST_IDX = 4'(N_COMB - 1);

endpackage

// File: rtl/q2_sweep_ctrl_if.sv
// rtl/q2_sweep_ctrl_if.sv - sweep request, q2 stimulus/response and truth-table bundle
interface q2_sweep_ctrl_if;

    logic        start;
    logic        a;
    logic        b;
    logic        c;
    logic        d;
    logic        f_in;
    logic        g_in;
    logic [3:0]  idx;
    logic        busy;
    logic        done;
    logic [15:0] f_table;
    logic [15:0] g_table;

    modport master (
        input  start, f_in, g_in,
        output a, b, c, d, idx, busy, done, f_table, g_table
    );

    modport slave (
        output start, f_in, g_in,
        input  a, b, c, d, idx, busy, done, f_table, g_table
    );

endinterface

// File: rtl/q2_sweep_ctrl_dwell_counter.sv
// rtl/q2_sweep_ctrl_dwell_counter.sv - counts 0..DWELL-1 per combination, flags the last dwell cycle
module q2_sweep_ctrl_dwell_counter #(
    parameter int DWELL = 4,
    parameter int CNT_W = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tc = (cnt_q == CNT_W'(DWELL - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tc ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/q2_sweep_ctrl.sv
// rtl/q2_sweep_ctrl.sv - steps a,b,c,d through all 16 combinations and captures f/g truth tables
module q2_sweep_ctrl #(
    parameter int DWELL = 4,
    parameter int CNT_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    q2_sweep_ctrl_if.master bus
);

    import q2_sweep_ctrl_pkg::*;

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [15:0] f_table_q, f_table_d;
    logic [15:0] g_table_q, g_table_d;
    logic        cnt_clr;
    logic        cnt_en;
    logic        cnt_tc;

    q2_sweep_ctrl_dwell_counter #(
        .DWELL (DWELL),
        .CNT_W (CNT_W)
    ) u_dwell (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .en  (cnt_en),
        .tc  (cnt_tc)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        busy_d    = busy_q;
        done_d    = done_q;
        f_table_d = f_table_q;
        g_table_d = g_table_q;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_d   = S_RUN;
                    idx_d     = '0;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    f_table_d = '0;
                    g_table_d = '0;
                    cnt_clr   = 1'b1;
                end
            end
            S_RUN: begin
                cnt_en = 1'b1;
                // f/g have had DWELL-1 cycles to settle since idx last moved
                if (cnt_tc) begin
                    f_table_d[idx_q] = bus.f_in;
                    g_table_d[idx_q] = bus.g_in;
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            f_table_q <= '0;
            g_table_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            f_table_q <= f_table_d;
            g_table_q <= g_table_d;
        end
    end

    // Stimulus is the idx register itself, so a..d move on the same edge as idx
    assign bus.a       = idx_q[3];
    assign bus.b       = idx_q[2];
    assign bus.c       = idx_q[1];
    assign bus.d       = idx_q[0];
    assign bus.idx     = idx_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.f_table = f_table_q;
    assign bus.g_table = g_table_q;

endmodule

// File: tb/tb_q2_sweep_ctrl.sv
// tb/tb_q2_sweep_ctrl.sv - randomized directed bench for q2_sweep_ctrl with f=a&b, g=c^d
module tb_q2_sweep_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst4;
    logic rst1;

    q2_sweep_ctrl_if if4 ();
    q2_sweep_ctrl_if if1 ();

    assign if4.f_in = if4.a & if4.b;
    assign if4.g_in = if4.c ^ if4.d;
    assign if1.f_in = if1.a & if1.b;
    assign if1.g_in = if1.c ^ if1.d;

    q2_sweep_ctrl #(.DWELL(4), .CNT_W(8)) dut4 (.clk(clk), .rst(rst4), .bus(if4));
    q2_sweep_ctrl #(.DWELL(1), .CNT_W(8)) dut1 (.clk(clk), .rst(rst1), .bus(if1));

    int          vectors     = 0;
    int          miscompares = 0;
    logic [15:0] ft;
    logic [15:0] gt;

    // {busy, done, a, b, c, d, idx, f_table, g_table}
    logic [41:0] obs4;
    logic [41:0] obs1;
    assign obs4 = {if4.busy, if4.done, if4.a, if4.b, if4.c, if4.d, if4.idx, if4.f_table, if4.g_table};
    assign obs1 = {if1.busy, if1.done, if1.a, if1.b, if1.c, if1.d, if1.idx, if1.f_table, if1.g_table};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [41:0] obs, input logic [41:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // t cycles after the accepting edge: combination t/dw is driven and all earlier ones are captured
    function automatic logic [41:0] exp_run(input int dw, input int t);
        int          n;
        logic [15:0] m;
        n = t / dw;
        m = 16'((32'd1 << n) - 32'd1);
        return {2'b10, n[3:0], n[3:0], ft & m, gt & m};
    endfunction

    function automatic logic [41:0] exp_done();
        return {2'b01, 4'hF, 4'hF, ft, gt};
    endfunction

    task automatic run4(input int poke_at, input int rst_at, input string tag);
        for (int t = 0; t < 64; t++) begin
            if (t == rst_at) begin
                rst4      = 1'b1;
                if4.start = 1'b1;
                tick();
                chk({tag, "_rst"}, obs4, '0);
                rst4      = 1'b0;
                if4.start = 1'b0;
                tick();
                chk({tag, "_rst_idle"}, obs4, '0);
                return;
            end
            chk({tag, "_run"}, obs4, exp_run(4, t));
            if4.start = (t == poke_at);
            tick();
        end
        if4.start = 1'b0;
        chk({tag, "_done"}, obs4, exp_done());
    endtask

    initial begin
        int poke_at;
        int rst_at;
        int gap;

        for (int k = 0; k < 16; k++) begin
            ft[k] = k[3] & k[2];
            gt[k] = k[1] ^ k[0];
        end

        rst4 = 1'b1;
        rst1 = 1'b1;
        if4.start = 1'b1;
        if1.start = 1'b1;
        tick();
        tick();
        chk("reset4", obs4, '0);
        chk("reset1", obs1, '0);
        rst4 = 1'b0;
        rst1 = 1'b0;
        if4.start = 1'b0;
        if1.start = 1'b0;
        tick();
        chk("idle4", obs4, '0);

        if4.start = 1'b1;
        tick();
        run4(-1, -1, "sweep");

        gap = int'($urandom_range(1, 5));
        for (int i = 0; i < gap; i++) begin
            tick();
            chk("done_hold", obs4, exp_done());
        end

        poke_at = int'($urandom_range(1, 62));
        if4.start = 1'b1;
        tick();
        run4(poke_at, -1, "ignore_start");

        rst_at = int'($urandom_range(20, 40));
        if4.start = 1'b1;
        tick();
        run4(-1, rst_at, "mid_rst");
        if4.start = 1'b1;
        tick();
        run4(-1, -1, "after_rst");

        if4.start = 1'b1;
        tick();
        for (int t = 0; t < 64; t++) begin
            chk("b2b_first_run", obs4, exp_run(4, t));
            tick();
        end
        chk("b2b_first_done", obs4, exp_done());
        tick();
        run4(-1, -1, "b2b_second");

        if1.start = 1'b1;
        tick();
        if1.start = 1'b0;
        for (int t = 0; t < 16; t++) begin
            chk("dw1_run", obs1, exp_run(1, t));
            tick();
        end
        chk("dw1_done", obs1, exp_done());

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
